cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- Owns the CP0 architectural registers (BadVAddr, Count, Compare, Status, Cause, EPC) and drives the cp0_regfile_t bundle read by the COP0 execute unit.
- Arbitrates exceptions from both issue slots, timer/hardware interrupts, ERET and MTC0 writes into one commit per cycle.
- Produces the registered pipeline flush and redirect PC.
- Sits at the commit stage, between the two issue slots' exception info and the fetch redirect.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC (BEV=1).
- STATUS_RESET, 32'h0040_0000, Status value at reset (BEV=1, all others 0).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ext_int  in  6  hardware interrupt lines, level, sampled every cycle into Cause.IP[7:2]
- exc_valid  in  2  per-slot exception valid; [0]=first slot, [1]=second slot
- exc_code  in  2x5  per-slot ExcCode
- exc_pc  in  2x32  per-slot faulting PC
- exc_bd  in  2  per-slot branch-delay flag
- exc_badvaddr  in  2x32  per-slot bad address, used only for codes AdEL(4)/AdES(5)
- int_pc  in  32  PC of the oldest valid committing instruction (interrupt EPC)
- int_pc_valid  in  1  int_pc is a real instruction; interrupts are taken only when 1
- int_bd  in  1  int_pc is in a delay slot
- mt_regsel  in  8  {rd,sel} MTC0 target; 8'h00 = no write
- mt_data  in  32  MTC0 data
- eret_valid  in  1  ERET committing
- cp0_reg  out  cp0_regfile_t  current register values
- flush  out  1  registered pipeline flush
- flush_pc  out  32  redirect target, valid when flush=1
- int_pending  out  1  combinational: interrupt would be taken this cycle

Behaviour:
- Reset (asynchronous, resetn=0):
  - Status=STATUS_RESET; Cause, EPC, BadVAddr, Count and Compare = 0.
  - count_tick=0, flush=0, flush_pc=0.
- Count:
  - count_tick toggles every cycle; Count increments (mod 2^32) on cycles where count_tick=1, i.e. every 2nd cycle.
  - MTC0 Count loads mt_data and clears count_tick.
- Timer interrupt:
  - Cause.TI (bit 30) is set on the edge where the next Count value equals Compare.
  - Cleared only by an MTC0 to Compare.
  - IP[7] = ext_int[5] | TI.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]) & int_pc_valid.
- Event priority per cycle (exactly one event commits):
  1. interrupt
  2. slot0 exception
  3. slot1 exception
  4. ERET
  5. MTC0
- Any higher event suppresses all lower ones. MTC0 and ERET are dropped when any exception or interrupt is taken.
- Exception/interrupt commit (same clock edge):
  - Cause.ExcCode = code (0 for interrupt).
  - If Status.EXL=0: EPC = bd ? pc-4 : pc, and Cause.BD = bd. If EXL=1, EPC and BD are unchanged.
  - Status.EXL = 1.
  - BadVAddr = exc_badvaddr[slot] only for codes 4/5.
  - Next cycle: flush=1, flush_pc=EXC_VECTOR.
- ERET commit: Status.EXL=0; next cycle flush=1, flush_pc=EPC value before the edge.
- MTC0 write masks (all other bits read-only):
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - Compare: full word; also clears TI.
  - Count: full word.
  - EPC: full word.
  - BadVAddr: not writable.
  - Unknown regsel: ignored.
- flush is a single-cycle pulse and deasserts the following cycle unless a new event commits. Events in the flush cycle are still honoured; upstream masks its valids.
- Cause.IP[7:2] is refreshed every cycle, including on exception edges.

Decomposition:
- Shared package holds:
  - RS_* regsel constants.
  - ExcCode enum: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12.
  - Status/Cause bit-position localparams.
  - cp0_regfile_t.
- One natural sub-module: cp0_timer (Count, count_tick, Compare, TI; Compare-write clear input).

Test Plan:
- Reset: release resetn → Status=32'h0040_0000, Cause=0, flush=0; after 10 cycles Count=5.
- Timer: MTC0 Compare=8; Status IE=1, IM[7]=1, EXL=0 → TI sets when Count reaches 8; with int_pc_valid=1, int_pc=32'hBFC0_1000 → EPC=32'hBFC0_1000, ExcCode=0, EXL=1, flush=1 with flush_pc=32'hBFC0_0380 next cycle. MTC0 Compare afterwards clears TI.
- Dual exception: slot0 AdEL with badvaddr 32'h0000_1003 and slot1 SYS in the same cycle → ExcCode=4, BadVAddr=32'h0000_1003, slot0's PC in EPC.
- Delay slot: slot0 OV, pc=32'h8000_0104, bd=1 → EPC=32'h8000_0100, Cause.BD=1. Repeat with EXL=1 → EPC unchanged.
- ERET: EPC=32'h8000_0200, EXL=1, eret_valid → EXL=0 and next cycle flush=1, flush_pc=32'h8000_0200. ERET together with slot0 exception → exception wins.
- MTC0 masking: Status write of 32'hFFFF_FFFF → Status=32'h0040_FF03. Cause write of 32'hFFFF_FFFF → only IP[9:8] set. MTC0 coinciding with an exception is dropped. resetn asserted mid-flush → flush=0 immediately.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: MTC0 register selectors, exception codes,
// Status/Cause bit positions and the register bundle seen by the COP0 unit.
package cp0_exc_ctrl_pkg;

    // Selectors are {rd[4:0], sel[2:0]}; 8'h00 means "no write this cycle".
    localparam logic [7:0] RS_NONE     = 8'h00;
    localparam logic [7:0] RS_BADVADDR = 8'h40;
    localparam logic [7:0] RS_COUNT    = 8'h48;
    localparam logic [7:0] RS_COMPARE  = 8'h58;
    localparam logic [7:0] RS_STATUS   = 8'h60;
    localparam logic [7:0] RS_CAUSE    = 8'h68;
    localparam logic [7:0] RS_EPC      = 8'h70;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } cp0_regfile_t;

    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// Count/Compare match and is cleared only by a Compare write.
module cp0_timer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        ti_q, ti_d;

    // The match is taken against the value Count will hold after this edge.
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + 32'(tick_q);
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
            tick_d  = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (count_d == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: owns the CP0 registers, commits one event per
// cycle (interrupt > slot0 > slot1 > ERET > MTC0) and issues the flush/redirect.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [5:0]       ext_int_i,
    input  logic [1:0]       exc_valid_i,
    input  logic [1:0][4:0]  exc_code_i,
    input  logic [1:0][31:0] exc_pc_i,
    input  logic [1:0]       exc_bd_i,
    input  logic [1:0][31:0] exc_badvaddr_i,
    input  logic [31:0]      int_pc_i,
    input  logic             int_pc_valid_i,
    input  logic             int_bd_i,
    input  logic [7:0]       mt_regsel_i,
    input  logic [31:0]      mt_data_i,
    input  logic             eret_valid_i,
    output cp0_regfile_t     cp0_reg_o,
    output logic             flush_o,
    output logic [31:0]      flush_pc_o,
    output logic             int_pending_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        cause_bd_q, cause_bd_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_pc_q, flush_pc_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic [31:0] cause;

    logic        take_exc, take_eret, take_mt;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc, sel_bva;
    logic        sel_bd;

    cp0_timer u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .count_we_i   (take_mt && (mt_regsel_i == RS_COUNT)),
        .compare_we_i (take_mt && (mt_regsel_i == RS_COMPARE)),
        .wdata_i      (mt_data_i),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    assign ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign cause = {cause_bd_q, ti, 14'b0, ip, 1'b0, cause_exc_q, 2'b0};

    assign int_pending_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                         & (|(ip & status_q[STATUS_IM_LO+7:STATUS_IM_LO]))
                         & int_pc_valid_i;

    // An interrupt is treated as an exception with code 0 taken at int_pc.
    always_comb begin
        take_exc = 1'b1;
        sel_code = EXC_INT;
        sel_pc   = int_pc_i;
        sel_bd   = int_bd_i;
        sel_bva  = badvaddr_q;
        if (int_pending_o) begin
            sel_code = EXC_INT;
        end else if (exc_valid_i[0]) begin
            sel_code = exc_code_i[0];
            sel_pc   = exc_pc_i[0];
            sel_bd   = exc_bd_i[0];
            sel_bva  = exc_badvaddr_i[0];
        end else if (exc_valid_i[1]) begin
            sel_code = exc_code_i[1];
            sel_pc   = exc_pc_i[1];
            sel_bd   = exc_bd_i[1];
            sel_bva  = exc_badvaddr_i[1];
        end else begin
            take_exc = 1'b0;
        end
    end

    assign take_eret = eret_valid_i & ~take_exc;
    assign take_mt   = (mt_regsel_i != RS_NONE) & ~take_exc & ~eret_valid_i;

    // A nested exception (EXL already set) keeps the original EPC and BD.
    always_comb begin
        status_d    = status_q;
        epc_d       = epc_q;
        badvaddr_d  = badvaddr_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        ip_sw_d     = ip_sw_q;
        flush_d     = 1'b0;
        flush_pc_d  = flush_pc_q;
        if (take_exc) begin
            cause_exc_d = sel_code;
            if (!status_q[STATUS_EXL]) begin
                epc_d      = sel_bd ? (sel_pc - 32'd4) : sel_pc;
                cause_bd_d = sel_bd;
            end
            status_d[STATUS_EXL] = 1'b1;
            if (has_badvaddr(sel_code)) begin
                badvaddr_d = sel_bva;
            end
            flush_d    = 1'b1;
            flush_pc_d = EXC_VECTOR;
        end else if (take_eret) begin
            status_d[STATUS_EXL] = 1'b0;
            flush_d    = 1'b1;
            flush_pc_d = epc_q;
        end else if (take_mt) begin
            case (mt_regsel_i)
                RS_STATUS: status_d = (status_q & ~STATUS_WMASK) | (mt_data_i & STATUS_WMASK);
                RS_CAUSE:  ip_sw_d  = mt_data_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
                RS_EPC:    epc_d    = mt_data_i;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q    <= STATUS_RESET;
            epc_q       <= '0;
            badvaddr_q  <= '0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= '0;
            ip_hw_q     <= '0;
            ip_sw_q     <= '0;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
        end else begin
            status_q    <= status_d;
            epc_q       <= epc_d;
            badvaddr_q  <= badvaddr_d;
            cause_bd_q  <= cause_bd_d;
            cause_exc_q <= cause_exc_d;
            ip_hw_q     <= ext_int_i;
            ip_sw_q     <= ip_sw_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
        end
    end

    assign cp0_reg_o = '{badvaddr: badvaddr_q, count: count, compare: compare,
                         status: status_q, cause: cause, epc: epc_q};
    assign flush_o    = flush_q;
    assign flush_pc_o = flush_pc_q;

endmodule
